// File: rtl/free_list.sv
// Physical-register free list for the rename stage.
// Circular buffer with speculative head, committed head and insert tail.
module free_list #(
    parameter int N_WAY   = 3,
    parameter int N_PR    = 64,
    parameter int N_AR    = 32,
    parameter int PR_BITS = 6,
    parameter int N_FL    = N_PR - N_AR,
    parameter int PW      = $clog2(N_FL),
    parameter int FCW     = $clog2(N_FL) + 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_WAY-1:0]         alloc_req,
    input  logic                     rollback,
    input  logic [N_WAY-1:0]         retire_valid,
    input  logic [N_WAY*PR_BITS-1:0] retire_told,
    output logic [N_WAY*PR_BITS-1:0] pr_freelist,
    output logic [FCW-1:0]           free_count,
    output logic                     dispatch_stall,
    output logic                     fl_error
);

    localparam int CW = $clog2(N_WAY + 1);

    logic [PR_BITS-1:0] fl_q [N_FL];
    logic [PW-1:0]      head_q, head_d;
    logic [PW-1:0]      arch_head_q, arch_head_d;
    logic [PW-1:0]      tail_q, tail_d;
    logic [FCW-1:0]     count_q, count_d;
    logic               err_q, err_d;

    logic [CW-1:0]      alloc_rank [N_WAY];
    logic [CW-1:0]      ret_rank [N_WAY];
    logic [CW-1:0]      rd_off [N_WAY];
    logic [CW-1:0]      k, r, k_acc;
    logic               reject;
    logic [FCW:0]       sum;

    function automatic logic [PW-1:0] ptr_add(
        input logic [PW-1:0] p,
        input logic [CW-1:0] n
    );
        logic [PW:0] s;
        s = {1'b0, p} + (PW+1)'(n);
        if (s >= (PW+1)'(N_FL))
            s = s - (PW+1)'(N_FL);
        return s[PW-1:0];
    endfunction

    // Lane ranks for packing grants and retire writes
    always_comb begin
        k = '0;
        r = '0;
        for (int j = 0; j < N_WAY; j++) begin
            alloc_rank[j] = k;
            ret_rank[j]   = r;
            // idle lanes preview the unpacked slot so an idle group shows head..head+N_WAY-1
            rd_off[j]     = alloc_req[j] ? k : CW'(j);
            k = k + CW'(alloc_req[j]);
            r = r + CW'(retire_valid[j]);
        end
    end

    // Grant read-out from the speculative head
    always_comb begin
        pr_freelist = '0;
        for (int j = 0; j < N_WAY; j++)
            pr_freelist[j*PR_BITS +: PR_BITS] = fl_q[ptr_add(head_q, rd_off[j])];
    end

    // Pointer, count and error next-state
    always_comb begin
        reject      = !rollback && (FCW'(k) > count_q);
        k_acc       = (rollback || reject) ? '0 : k;
        tail_d      = ptr_add(tail_q, r);
        arch_head_d = ptr_add(arch_head_q, r);
        sum         = {1'b0, count_q} - (FCW+1)'(k_acc) + (FCW+1)'(r);
        err_d       = err_q | reject;
        head_d      = ptr_add(head_q, k_acc);
        count_d     = sum[FCW-1:0];
        if (rollback) begin
            head_d  = arch_head_d;
            count_d = FCW'(N_FL);
        end else if (sum > (FCW+1)'(N_FL)) begin
            count_d = FCW'(N_FL);
            err_d   = 1'b1;
        end
    end

    // Pointer and status registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q      <= '0;
            arch_head_q <= '0;
            tail_q      <= '0;
            count_q     <= FCW'(N_FL);
            err_q       <= 1'b0;
        end else begin
            head_q      <= head_d;
            arch_head_q <= arch_head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            err_q       <= err_d;
        end
    end

    // Storage: reload identity list on reset, append retired Told in lane order
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_FL; i++)
                fl_q[i] <= PR_BITS'(N_AR + i);
        end else begin
            for (int j = 0; j < N_WAY; j++)
                if (retire_valid[j])
                    fl_q[ptr_add(tail_q, ret_rank[j])] <=
                        retire_told[j*PR_BITS +: PR_BITS];
        end
    end

    assign free_count     = count_q;
    assign dispatch_stall = count_q < FCW'(N_WAY);
    assign fl_error       = err_q;

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list.
// Each scenario task drives vectors and checks against hand-computed values.
module tb_free_list;

    logic        clock;
    logic        reset;
    logic [2:0]  alloc_req;
    logic        rollback;
    logic [2:0]  retire_valid;
    logic [17:0] retire_told;
    logic [17:0] pr_freelist;
    logic [5:0]  free_count;
    logic        dispatch_stall;
    logic        fl_error;

    int checks;
    int errors;

    free_list dut (
        .clock          (clock),
        .reset          (reset),
        .alloc_req      (alloc_req),
        .rollback       (rollback),
        .retire_valid   (retire_valid),
        .retire_told    (retire_told),
        .pr_freelist    (pr_freelist),
        .free_count     (free_count),
        .dispatch_stall (dispatch_stall),
        .fl_error       (fl_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic clear_inputs();
        alloc_req    = 3'b000;
        rollback     = 1'b0;
        retire_valid = 3'b000;
        retire_told  = '0;
    endtask

    task automatic edge1();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        edge1();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (pr_freelist !== {6'd34, 6'd33, 6'd32}) begin
            errors++;
            $display("FAIL reset_pr got %h exp %h", pr_freelist, {6'd34, 6'd33, 6'd32});
        end
        checks++;
        if (free_count !== 6'd32) begin
            errors++;
            $display("FAIL reset_count got %0d exp 32", free_count);
        end
        checks++;
        if (dispatch_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall got %b exp 0", dispatch_stall);
        end
        checks++;
        if (fl_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_err got %b exp 0", fl_error);
        end
    endtask

    task automatic test_alloc_full();
        do_reset();
        alloc_req = 3'b111;
        #1;
        checks++;
        if (pr_freelist !== {6'd34, 6'd33, 6'd32}) begin
            errors++;
            $display("FAIL alloc111_grant got %h exp %h", pr_freelist, {6'd34, 6'd33, 6'd32});
        end
        edge1();
        alloc_req = 3'b000;
        #1;
        checks++;
        if (pr_freelist !== {6'd37, 6'd36, 6'd35}) begin
            errors++;
            $display("FAIL alloc111_next got %h exp %h", pr_freelist, {6'd37, 6'd36, 6'd35});
        end
        checks++;
        if (free_count !== 6'd29) begin
            errors++;
            $display("FAIL alloc111_count got %0d exp 29", free_count);
        end
    endtask

    task automatic test_alloc_sparse();
        do_reset();
        alloc_req = 3'b101;
        #1;
        checks++;
        if (pr_freelist[5:0] !== 6'd32) begin
            errors++;
            $display("FAIL sparse_lane0 got %0d exp 32", pr_freelist[5:0]);
        end
        checks++;
        if (pr_freelist[17:12] !== 6'd33) begin
            errors++;
            $display("FAIL sparse_lane2 got %0d exp 33", pr_freelist[17:12]);
        end
        edge1();
        alloc_req = 3'b000;
        #1;
        checks++;
        if (pr_freelist[5:0] !== 6'd34) begin
            errors++;
            $display("FAIL sparse_next got %0d exp 34", pr_freelist[5:0]);
        end
        checks++;
        if (free_count !== 6'd30) begin
            errors++;
            $display("FAIL sparse_count got %0d exp 30", free_count);
        end
    endtask

    task automatic test_exhaust_wrap();
        do_reset();
        alloc_req = 3'b111;
        for (int i = 0; i < 10; i++)
            edge1();
        alloc_req = 3'b000;
        #1;
        checks++;
        if (free_count !== 6'd2) begin
            errors++;
            $display("FAIL exh_count got %0d exp 2", free_count);
        end
        checks++;
        if (dispatch_stall !== 1'b1) begin
            errors++;
            $display("FAIL exh_stall got %b exp 1", dispatch_stall);
        end
        checks++;
        if (fl_error !== 1'b0) begin
            errors++;
            $display("FAIL exh_err_early got %b exp 0", fl_error);
        end
        alloc_req = 3'b111;
        edge1();
        alloc_req = 3'b000;
        #1;
        checks++;
        if (fl_error !== 1'b1) begin
            errors++;
            $display("FAIL reject_err got %b exp 1", fl_error);
        end
        checks++;
        if (free_count !== 6'd2 || pr_freelist[5:0] !== 6'd62) begin
            errors++;
            $display("FAIL reject_hold got cnt %0d pr %0d exp cnt 2 pr 62",
                     free_count, pr_freelist[5:0]);
        end
        retire_valid = 3'b011;
        retire_told  = {6'd0, 6'd7, 6'd5};
        edge1();
        clear_inputs();
        #1;
        checks++;
        if (free_count !== 6'd4) begin
            errors++;
            $display("FAIL retire_count got %0d exp 4", free_count);
        end
        alloc_req = 3'b111;
        #1;
        checks++;
        if (pr_freelist !== {6'd5, 6'd63, 6'd62}) begin
            errors++;
            $display("FAIL wrap_grant got %h exp %h", pr_freelist, {6'd5, 6'd63, 6'd62});
        end
        edge1();
        alloc_req = 3'b001;
        #1;
        checks++;
        if (pr_freelist[5:0] !== 6'd7) begin
            errors++;
            $display("FAIL wrap_second got %0d exp 7", pr_freelist[5:0]);
        end
        edge1();
        alloc_req = 3'b000;
        #1;
        checks++;
        if (free_count !== 6'd0 || dispatch_stall !== 1'b1) begin
            errors++;
            $display("FAIL empty got cnt %0d stall %b exp cnt 0 stall 1",
                     free_count, dispatch_stall);
        end
    endtask

    task automatic test_rollback();
        do_reset();
        alloc_req = 3'b111;
        for (int i = 0; i < 3; i++)
            edge1();
        alloc_req = 3'b000;
        #1;
        checks++;
        if (free_count !== 6'd23) begin
            errors++;
            $display("FAIL rb_pre_count got %0d exp 23", free_count);
        end
        rollback     = 1'b1;
        alloc_req    = 3'b111;
        retire_valid = 3'b001;
        retire_told  = {6'd0, 6'd0, 6'd2};
        edge1();
        clear_inputs();
        #1;
        checks++;
        if (free_count !== 6'd32) begin
            errors++;
            $display("FAIL rb_count got %0d exp 32", free_count);
        end
        checks++;
        if (pr_freelist !== {6'd35, 6'd34, 6'd33}) begin
            errors++;
            $display("FAIL rb_grant got %h exp %h", pr_freelist, {6'd35, 6'd34, 6'd33});
        end
        checks++;
        if (fl_error !== 1'b0) begin
            errors++;
            $display("FAIL rb_err got %b exp 0", fl_error);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        retire_valid = 3'b001;
        retire_told  = {6'd0, 6'd0, 6'd9};
        edge1();
        clear_inputs();
        #1;
        checks++;
        if (free_count !== 6'd32) begin
            errors++;
            $display("FAIL ovf_count got %0d exp 32", free_count);
        end
        checks++;
        if (fl_error !== 1'b1) begin
            errors++;
            $display("FAIL ovf_err got %b exp 1", fl_error);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        alloc_req    = 3'b111;
        retire_valid = 3'b111;
        retire_told  = {6'd3, 6'd2, 6'd1};
        edge1();
        edge1();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (free_count !== 6'd32 || fl_error !== 1'b0) begin
            errors++;
            $display("FAIL arst_state got cnt %0d err %b exp cnt 32 err 0",
                     free_count, fl_error);
        end
        checks++;
        if (pr_freelist !== {6'd34, 6'd33, 6'd32}) begin
            errors++;
            $display("FAIL arst_pr got %h exp %h", pr_freelist, {6'd34, 6'd33, 6'd32});
        end
        clear_inputs();
        edge1();
        reset = 1'b1;
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        clear_inputs();
        test_reset();
        test_alloc_full();
        test_alloc_sparse();
        test_exhaust_wrap();
        test_rollback();
        test_overflow();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
